// File: rtl/seq_serial_tx_if.sv
// rtl/seq_serial_tx_if.sv - word-in / bit-out handshake bundle for seq_serial_tx
interface seq_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;
  logic [1:0]       PS_out;

  // word source / serial-line observer
  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, busy, done, PS_out
  );

  // transmitter side
  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, busy, done, PS_out
  );
endinterface

// File: rtl/seq_serial_tx.sv
// rtl/seq_serial_tx.sv - MSB-first parallel-to-serial bit transmitter with optional inter-word gap
module seq_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 0
) (
  input  logic            clk,
  input  logic            rst,
  seq_serial_tx_if.slave  bus
);

  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int BIT_W   = (WIDTH > 2)        ? $clog2(WIDTH)        : 1;
  localparam int DIV_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W   = (GAP_CYC > 1)      ? $clog2(GAP_CYC)      : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             done_q;

  logic div_wrap, last_bit, gap_end;

  assign div_wrap = (div_cnt == DIV_W'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));
  // only meaningful when GAP_CYC > 0; GAP is never entered otherwise
  assign gap_end  = (gap_cnt == GAP_W'(GAP_CYC - 1));

  // present-state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state decode; the unused code 2'b11 falls back to IDLE
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.din_valid ? SHIFT : IDLE;
      SHIFT: begin
        state_nxt = SHIFT;
        if (div_wrap && last_bit) state_nxt = (GAP_BITS > 0) ? GAP : IDLE;
      end
      GAP:     state_nxt = gap_end ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: word capture, bit-time divider, shifting, gap timer and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            shreg   <= bus.din;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            if (last_bit) begin
              // clear rather than increment so the counter never wraps past WIDTH-1
              bit_cnt <= '0;
              done_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dout       = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign bus.dout_valid = (state == SHIFT);
  assign bus.busy       = (state != IDLE);
  assign bus.din_ready  = (state == IDLE);
  assign bus.done       = done_q;
  assign bus.PS_out     = state;

endmodule

// File: tb/tb_seq_serial_tx.sv
// tb/tb_seq_serial_tx.sv - directed self-checking bench for seq_serial_tx
module tb_seq_serial_tx;

  logic clk;
  logic rst;
  int   ncmp;
  int   nfail;

  seq_serial_tx_if #(.WIDTH(8)) if_a ();
  seq_serial_tx_if #(.WIDTH(8)) if_b ();
  seq_serial_tx_if #(.WIDTH(8)) if_c ();

  seq_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .GAP_BITS(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  seq_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(3), .GAP_BITS(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  seq_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .GAP_BITS(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one word through dut_a; optional busy-time din_valid pulse; 101 hits by bit index
  task automatic run_a(input logic [7:0] word, input bit inject, output logic [7:0] hits);
    logic [2:0] hist;
    hist = 3'b000;
    hits = 8'h00;
    if_a.din = word;
    if_a.din_valid = 1'b1;
    step();
    if_a.din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (inject && k == 2) begin
        if_a.din = 8'h0F;
        if_a.din_valid = 1'b1;
      end
      if (inject && k == 3) if_a.din_valid = 1'b0;
      chk($sformatf("a_dout_bit%0d", k), 32'(if_a.dout), 32'(word[7-k]));
      chk("a_dout_valid", 32'(if_a.dout_valid), 32'd1);
      chk("a_din_ready_busy", 32'(if_a.din_ready), 32'd0);
      hist = {hist[1:0], if_a.dout};
      if (k >= 2 && hist == 3'b101) hits[k] = 1'b1;
      step();
    end
    chk("a_done_c9", 32'(if_a.done), 32'd1);
    chk("a_dout_valid_c9", 32'(if_a.dout_valid), 32'd0);
    chk("a_din_ready_c9", 32'(if_a.din_ready), 32'd1);
    step();
    chk("a_done_c10", 32'(if_a.done), 32'd0);
    chk("a_ps_c10", 32'(if_a.PS_out), 32'd0);
    chk("a_dout_valid_c10", 32'(if_a.dout_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] hits;
    logic [7:0] wb;
    ncmp  = 0;
    nfail = 0;
    rst = 1'b0;
    if_a.din = '0; if_a.din_valid = 1'b0;
    if_b.din = '0; if_b.din_valid = 1'b0;
    if_c.din = '0; if_c.din_valid = 1'b0;
    step(); step(); step();

    chk("rst_dout", 32'(if_a.dout), 32'd0);
    chk("rst_dout_valid", 32'(if_a.dout_valid), 32'd0);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_din_ready", 32'(if_a.din_ready), 32'd1);
    chk("rst_done", 32'(if_a.done), 32'd0);
    chk("rst_ps", 32'(if_a.PS_out), 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_ps", 32'(if_a.PS_out), 32'd0);
    chk("post_rst_ps_c", 32'(if_c.PS_out), 32'd0);

    // single word A5 at defaults, with 101 hits at bits 2 and 7
    run_a(8'hA5, 1'b0, hits);
    chk("a5_hits", 32'(hits), 32'h84);

    // ignore din_valid while shifting
    run_a(8'hA5, 1'b1, hits);
    chk("ignore_hits", 32'(hits), 32'h84);

    // loopback into a 101 detector: overlapping hits at bits 2 and 4
    run_a(8'hA8, 1'b0, hits);
    chk("loop_hits", 32'(hits), 32'h14);

    // CLKS_PER_BIT=3, C3 -> 1,1,0,0,0,0,1,1 each held 3 cycles
    wb = 8'hC3;
    if_b.din = wb;
    if_b.din_valid = 1'b1;
    step();
    if_b.din_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      chk($sformatf("b_dout_c%0d", c), 32'(if_b.dout), 32'(wb[7 - (c - 1) / 3]));
      chk("b_done_low", 32'(if_b.done), 32'd0);
      step();
    end
    chk("b_done_c25", 32'(if_b.done), 32'd1);
    chk("b_ps_c25", 32'(if_b.PS_out), 32'd0);

    // GAP_BITS=2: FF then 00 with din_valid held high
    if_c.din = 8'hFF;
    if_c.din_valid = 1'b1;
    step();
    if_c.din = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("c_ps_c%0d", c), 32'(if_c.PS_out), 32'd1);
      chk("c_din_ready_shift", 32'(if_c.din_ready), 32'd0);
      chk("c_dout_ff", 32'(if_c.dout), 32'd1);
      step();
    end
    chk("c_ps_c9", 32'(if_c.PS_out), 32'd2);
    chk("c_done_c9", 32'(if_c.done), 32'd1);
    chk("c_busy_c9", 32'(if_c.busy), 32'd1);
    chk("c_din_ready_c9", 32'(if_c.din_ready), 32'd0);
    chk("c_dout_c9", 32'(if_c.dout), 32'd0);
    chk("c_dout_valid_c9", 32'(if_c.dout_valid), 32'd0);
    step();
    chk("c_ps_c10", 32'(if_c.PS_out), 32'd2);
    chk("c_done_c10", 32'(if_c.done), 32'd0);
    chk("c_din_ready_c10", 32'(if_c.din_ready), 32'd0);
    step();
    chk("c_ps_c11", 32'(if_c.PS_out), 32'd0);
    chk("c_din_ready_c11", 32'(if_c.din_ready), 32'd1);
    step();
    if_c.din_valid = 1'b0;
    chk("c_ps_c12", 32'(if_c.PS_out), 32'd1);
    chk("c_dout_c12", 32'(if_c.dout), 32'd0);
    chk("c_dout_valid_c12", 32'(if_c.dout_valid), 32'd1);
    for (int c = 0; c < 8; c++) step();
    chk("c_done_c20", 32'(if_c.done), 32'd1);
    chk("c_ps_c20", 32'(if_c.PS_out), 32'd2);
    step(); step();
    chk("c_ps_c22", 32'(if_c.PS_out), 32'd0);

    // reset mid-word: immediate idle outputs, no resume, no done
    if_a.din = 8'hA5;
    if_a.din_valid = 1'b1;
    step();
    if_a.din_valid = 1'b0;
    step(); step(); step();
    chk("mid_ps_before", 32'(if_a.PS_out), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(if_a.dout), 32'd0);
    chk("mid_rst_dout_valid", 32'(if_a.dout_valid), 32'd0);
    chk("mid_rst_busy", 32'(if_a.busy), 32'd0);
    chk("mid_rst_din_ready", 32'(if_a.din_ready), 32'd1);
    chk("mid_rst_done", 32'(if_a.done), 32'd0);
    chk("mid_rst_ps", 32'(if_a.PS_out), 32'd0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("mid_post_ps", 32'(if_a.PS_out), 32'd0);
      chk("mid_post_done", 32'(if_a.done), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
